// File: rtl/lcd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_arbiter
//  Brief    : Two-port round-robin front end sharing one lcd_ctrl window engine.
//  Revision : 1.0
// ============================================================================
module lcd_cmd_arbiter #(
    parameter int TIMEOUT  = 16,
    parameter int LOAD_LEN = 36,
    parameter int WIN_LEN  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [2:0] req0_cmd,
    output logic       req0_ready,
    input  logic [7:0] req0_data,
    output logic       req0_data_ack,
    input  logic       req1_valid,
    input  logic [2:0] req1_cmd,
    output logic       req1_ready,
    input  logic [7:0] req1_data,
    output logic       req1_data_ack,
    output logic [2:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    output logic [7:0] lcd_datain,
    input  logic [7:0] lcd_dataout,
    input  logic       lcd_output_valid,
    input  logic       lcd_busy,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_done,
    output logic       cmd_err,
    output logic       timeout_err
);

    localparam int                c_wdog_w    = $clog2(TIMEOUT + 1);
    localparam logic [5:0]        c_byte_last = 6'(LOAD_LEN - 1);
    localparam logic [3:0]        c_beat_last = 4'(WIN_LEN - 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);
    localparam logic [2:0]        c_cmd_load  = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  r_grant;
    logic [2:0]            r_cmd;
    logic [5:0]            r_byte_cnt;
    logic [3:0]            r_beat_cnt;
    logic [c_wdog_w-1:0]   r_wdog;
    logic                  r_timeout_err;

    logic                  w_grant;
    logic [2:0]            w_sel_cmd;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_wdog_on;
    logic                  w_wdog_hit;

    // Tie goes to the port that did not win last time.
    assign w_grant    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_sel_cmd  = w_grant ? req1_cmd : req0_cmd;
    assign w_illegal  = (w_sel_cmd[2:1] == 2'b11);
    assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign w_beat     = (r_state == S_DRAIN) && lcd_output_valid;
    assign w_wdog_on  = (r_state == S_DRAIN) || (r_state == S_DONE);
    // A completion in DONE takes priority over a coincident watchdog expiry.
    assign w_wdog_hit = ((r_state == S_DRAIN) || ((r_state == S_DONE) && lcd_busy))
                        && !w_beat && (r_wdog == c_wdog_last);

    assign timeout_err = r_timeout_err;

    always_comb begin
        w_state_nxt   = r_state;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        req0_data_ack = 1'b0;
        req1_data_ack = 1'b0;
        lcd_cmd       = 3'd0;
        lcd_cmd_valid = 1'b0;
        lcd_datain    = 8'd0;
        rsp_data      = 8'd0;
        rsp_valid     = 1'b0;
        rsp_id        = 1'b0;
        rsp_done      = 1'b0;
        cmd_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req0_ready = ~w_grant;
                    req1_ready = w_grant;
                    rsp_id     = w_grant;
                    cmd_err    = w_illegal;
                    if (!w_illegal) w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lcd_cmd_valid = 1'b1;
                lcd_cmd       = r_cmd;
                rsp_id        = r_grant;
                w_state_nxt   = (r_cmd == c_cmd_load) ? S_LOAD : S_DRAIN;
            end
            S_LOAD: begin
                rsp_id        = r_grant;
                lcd_datain    = r_grant ? req1_data : req0_data;
                req0_data_ack = ~r_grant;
                req1_data_ack = r_grant;
                if (r_byte_cnt == c_byte_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                rsp_id = r_grant;
                if (w_beat) begin
                    rsp_valid = 1'b1;
                    rsp_data  = lcd_dataout;
                    if (r_beat_cnt == c_beat_last) w_state_nxt = S_DONE;
                end else if (w_wdog_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                rsp_id = r_grant;
                if (!lcd_busy) begin
                    rsp_done    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_wdog_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_cmd         <= 3'd0;
            r_byte_cnt    <= 6'd0;
            r_beat_cnt    <= 4'd0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_grant      <= w_grant;
                r_cmd        <= w_sel_cmd;
            end
            if ((r_state == S_LOAD) && (r_byte_cnt != c_byte_last))
                r_byte_cnt <= r_byte_cnt + 6'd1;
            else
                r_byte_cnt <= 6'd0;
            if (r_state != S_DRAIN)
                r_beat_cnt <= 4'd0;
            else if (w_beat)
                r_beat_cnt <= (r_beat_cnt == c_beat_last) ? 4'd0 : r_beat_cnt + 4'd1;
            // Held at zero outside DRAIN/DONE so DRAIN entry starts a fresh window.
            if (w_wdog_on && !w_beat)
                r_wdog <= r_wdog + c_wdog_w'(1);
            else
                r_wdog <= '0;
            if (w_wdog_hit) r_timeout_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
